// File: rtl/md_sequencer.sv
// Execute-stage sequencer for the multi-cycle multiply/divide unit: issues the
// start pulse, stalls the front of the pipe, and presents result or exception writeback.
module md_sequencer #(
    parameter int MAX_WAIT = 40,
    parameter int CNT_W    = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] x_instr,
    input  logic        x_valid,
    input  logic        flush,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall,
    output logic        busy,
    output logic        md_done,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              op_div_r;
    logic              start_r;
    logic              exc_r;
    logic [4:0]        rd_r;
    logic [31:0]       result_r;

    logic              is_mul_s;
    logic              is_div_s;
    logic              trigger_s;
    logic              ready_ok_s;
    logic              timeout_s;
    logic              unused_s;

    // The reset term keeps the combinational stall low while the block is held in reset.
    assign is_mul_s   = (x_instr[31:27] == 5'b00000) && (x_instr[6:2] == 5'b00110);
    assign is_div_s   = (x_instr[31:27] == 5'b00000) && (x_instr[6:2] == 5'b00111);
    assign trigger_s  = reset && x_valid && !flush && (is_mul_s || is_div_s);
    assign ready_ok_s = md_ready && (cnt_r != {CNT_W{1'b0}});
    assign timeout_s  = (cnt_r == CNT_W'(MAX_WAIT));
    assign unused_s   = ^{x_instr[21:7], x_instr[1:0]};

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; flush outranks completion, md_ready outranks timeout
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (ready_ok_s || timeout_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Operation context: op/rd latch, start pulse, wait counter, result capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r    <= {CNT_W{1'b0}};
            op_div_r <= 1'b0;
            start_r  <= 1'b0;
            exc_r    <= 1'b0;
            rd_r     <= 5'd0;
            result_r <= 32'd0;
        end else begin
            start_r <= (state_r == ST_IDLE) && trigger_s;
            if ((state_r == ST_IDLE) && trigger_s) begin
                cnt_r    <= {CNT_W{1'b0}};
                op_div_r <= is_div_s;
                rd_r     <= x_instr[26:22];
                exc_r    <= 1'b0;
                result_r <= 32'd0;
            end else if ((state_r == ST_BUSY) && !flush) begin
                if (cnt_r < CNT_W'(MAX_WAIT)) begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_r <= cnt_r;
                end
                if (ready_ok_s) begin
                    result_r <= md_result;
                    exc_r    <= md_exception;
                end else if (timeout_s) begin
                    exc_r    <= 1'b1;
                end else begin
                    exc_r    <= exc_r;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Output decode from the registered state
    always_comb begin
        stall     = 1'b0;
        busy      = 1'b0;
        md_done   = 1'b0;
        wb_en     = 1'b0;
        wb_reg    = 5'd0;
        wb_data   = 32'd0;
        ctrl_mult = start_r && !op_div_r;
        ctrl_div  = start_r && op_div_r;
        case (state_r)
            ST_IDLE: stall = trigger_s;
            ST_BUSY: begin
                stall = 1'b1;
                busy  = 1'b1;
            end
            ST_DONE: begin
                md_done = 1'b1;
                if (exc_r) begin
                    wb_en   = 1'b1;
                    wb_reg  = 5'd30;
                    wb_data = op_div_r ? 32'd5 : 32'd4;
                end else begin
                    wb_en   = (rd_r != 5'd0);
                    wb_reg  = rd_r;
                    wb_data = result_r;
                end
            end
            default: stall = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed scenarios plus randomized operations
// checked against a transaction-level expectation of each operation's outcome.
module tb_md_sequencer;

    localparam int MAX_WAIT = 40;

    logic        clock;
    logic        reset;
    logic [31:0] x_instr;
    logic        x_valid;
    logic        flush;
    logic        md_ready;
    logic        md_exception;
    logic [31:0] md_result;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        stall;
    logic        busy;
    logic        md_done;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    md_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .x_instr(x_instr), .x_valid(x_valid),
        .flush(flush), .md_ready(md_ready), .md_exception(md_exception),
        .md_result(md_result), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .stall(stall), .busy(busy), .md_done(md_done), .wb_en(wb_en),
        .wb_reg(wb_reg), .wb_data(wb_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " stall"},   32'(stall),     32'd0);
        chk({tag, " busy"},    32'(busy),      32'd0);
        chk({tag, " mult"},    32'(ctrl_mult), 32'd0);
        chk({tag, " div"},     32'(ctrl_div),  32'd0);
        chk({tag, " done"},    32'(md_done),   32'd0);
        chk({tag, " wb_en"},   32'(wb_en),     32'd0);
        chk({tag, " wb_reg"},  32'(wb_reg),    32'd0);
        chk({tag, " wb_data"}, wb_data,        32'd0);
    endtask

    function automatic logic [31:0] mk_instr(input bit is_div, input bit [4:0] rd);
        logic [14:0] mid;
        mid = 15'($urandom);
        return {5'b00000, rd, mid, (is_div ? 5'b00111 : 5'b00110), 2'b11};
    endfunction

    // Bubble / non-triggering cycle; entered just after a rising edge.
    task automatic idle_cycle();
        int kind;
        kind = $urandom_range(0, 2);
        flush = 1'b0;
        md_ready = 1'b0;
        if (kind == 0) begin
            x_valid = 1'b0;
            x_instr = mk_instr(1'b0, 5'd3);
        end else if (kind == 1) begin
            x_valid = 1'b1;
            x_instr = {5'b00001, 27'($urandom)};
        end else begin
            x_valid = 1'b1;
            flush   = 1'b1;
            x_instr = mk_instr(1'b1, 5'd4);
        end
        @(negedge clock);
        chk_quiet("idle");
        @(posedge clock); #1;
        flush = 1'b0;
    endtask

    // One mul/div operation. ready_k: BUSY cycle (1-based) carrying md_ready, 0 = never.
    // flush_k: BUSY cycle carrying flush, 0 = none. Entered/left just after a rising edge.
    task automatic run_op(input bit is_div, input bit [4:0] rd, input int ready_k,
                          input bit [31:0] res, input bit exc, input int flush_k);
        int          eff_end;
        bit          aborted;
        bit          timed_out;
        int          last;
        bit          exp_en;
        bit [4:0]    exp_reg;
        bit [31:0]   exp_data;

        // md_ready counts only from the second BUSY cycle; the wait expires on
        // the BUSY cycle where MAX_WAIT cycles have elapsed since the start pulse.
        timed_out = !(ready_k >= 2 && ready_k <= MAX_WAIT + 1);
        eff_end   = timed_out ? MAX_WAIT + 1 : ready_k;
        aborted   = (flush_k != 0) && (flush_k <= eff_end);
        last      = aborted ? flush_k : eff_end;
        if (timed_out || exc) begin
            exp_en = 1'b1; exp_reg = 5'd30; exp_data = is_div ? 32'd5 : 32'd4;
        end else begin
            exp_en = (rd != 5'd0); exp_reg = rd; exp_data = res;
        end

        x_instr = mk_instr(is_div, rd);
        x_valid = 1'b1;
        flush = 1'b0;
        md_ready = 1'b0;
        @(negedge clock);
        chk("trig stall", 32'(stall), 32'd1);
        chk("trig busy", 32'(busy), 32'd0);
        chk("trig pulse", 32'(ctrl_mult | ctrl_div), 32'd0);
        @(posedge clock); #1;

        for (int k = 1; k <= last; k++) begin
            md_ready     = (k == ready_k);
            md_result    = (k == ready_k) ? res : $urandom;
            md_exception = (k == ready_k) ? exc : 1'($urandom);
            flush        = (k == flush_k);
            @(negedge clock);
            chk("busy stall", 32'(stall), 32'd1);
            chk("busy busy", 32'(busy), 32'd1);
            chk("busy mult", 32'(ctrl_mult), 32'((k == 1) && !is_div));
            chk("busy div", 32'(ctrl_div), 32'((k == 1) && is_div));
            chk("busy done", 32'(md_done), 32'd0);
            chk("busy wb_en", 32'(wb_en), 32'd0);
            @(posedge clock); #1;
        end
        md_ready = 1'b0;
        flush = 1'b0;
        md_result = $urandom;

        if (aborted) begin
            x_valid = 1'b0;
            @(negedge clock);
            chk_quiet("abort");
            @(posedge clock); #1;
            md_ready = 1'b1;
            md_exception = 1'b1;
            @(negedge clock);
            chk_quiet("late ready");
            @(posedge clock); #1;
            md_ready = 1'b0;
            md_exception = 1'b0;
        end else begin
            // X still holds the instruction during DONE; it must not restart.
            @(negedge clock);
            chk("done md_done", 32'(md_done), 32'd1);
            chk("done stall", 32'(stall), 32'd0);
            chk("done busy", 32'(busy), 32'd0);
            chk("done pulse", 32'(ctrl_mult | ctrl_div), 32'd0);
            chk("done wb_en", 32'(wb_en), 32'(exp_en));
            chk("done wb_reg", 32'(wb_reg), 32'(exp_reg));
            chk("done wb_data", wb_data, exp_data);
            @(posedge clock); #1;
            x_valid = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b0;
        x_instr = 32'd0;
        x_valid = 1'b0;
        flush = 1'b0;
        md_ready = 1'b0;
        md_exception = 1'b0;
        md_result = 32'd0;
        #1;
        chk_quiet("reset");
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock); #1;
        idle_cycle();

        // Directed scenarios
        run_op(1'b0, 5'd5, 17, 32'h0000_002A, 1'b0, 0);
        idle_cycle();
        run_op(1'b1, 5'd7, 5, 32'h0000_0000, 1'b1, 0);
        idle_cycle();
        run_op(1'b0, 5'd0, 8, 32'h0000_1234, 1'b0, 0);
        idle_cycle();
        run_op(1'b0, 5'd9, 0, 32'h0, 1'b0, 0);
        idle_cycle();
        run_op(1'b1, 5'd11, 1, 32'hDEAD_BEEF, 1'b0, 0);
        idle_cycle();
        run_op(1'b0, 5'd12, MAX_WAIT + 1, 32'hCAFE_0001, 1'b0, 0);
        run_op(1'b0, 5'd2, 3, 32'h1111_2222, 1'b0, 0);
        run_op(1'b1, 5'd3, 6, 32'h3333_4444, 1'b0, 0);
        idle_cycle();
        run_op(1'b0, 5'd6, 10, 32'h5555, 1'b0, 3);
        idle_cycle();

        // Asynchronous reset in the middle of an operation
        x_instr = mk_instr(1'b0, 5'd4);
        x_valid = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        chk_quiet("mid reset");
        @(posedge clock); #1;
        x_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk_quiet("post reset");
        @(posedge clock); #1;
        run_op(1'b0, 5'd4, 4, 32'h0BAD_F00D, 1'b0, 0);

        // Randomized operations
        for (int i = 0; i < 25; i++) begin
            bit        r_div;
            bit [4:0]  r_rd;
            int        r_ready;
            int        r_flush;
            bit        r_exc;
            r_div   = 1'($urandom);
            r_rd    = 5'($urandom);
            r_ready = $urandom_range(1, MAX_WAIT + 5);
            if (r_ready > MAX_WAIT + 1) r_ready = 0;
            r_exc   = ($urandom_range(0, 3) == 0);
            r_flush = ($urandom_range(0, 3) == 0) ? $urandom_range(1, MAX_WAIT + 1) : 0;
            if (r_flush == r_ready) r_flush = 0;
            run_op(r_div, r_rd, r_ready, $urandom, r_exc, r_flush);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Execute-stage controller for the multi-cycle multiply/divide unit.
- Detects mul/div in X and issues a one-cycle start pulse to the unit.
- Holds F/D/X stalled until the unit reports ready (or a timeout fires), then presents the result or exception writeback for the X/M latch.
- Sits beside the ALU in X and drives the pipeline-wide stall for multdiv.

Parameters:
- MAX_WAIT, 40, cycles after the start pulse before a missing md_ready is treated as an exception.
- CNT_W, 6, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clock  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state
- x_instr  input  32  instruction in X stage
- x_valid  input  1  X holds a real (non-bubble) instruction
- flush  input  1  branch/jump squash of X this cycle
- md_ready  input  1  multdiv result valid
- md_exception  input  1  multdiv overflow / divide-by-zero, valid with md_ready
- md_result  input  32  multdiv result
- ctrl_mult  output  1  one-cycle multiply start pulse
- ctrl_div  output  1  one-cycle divide start pulse
- stall  output  1  freeze PC, F/D, D/X; insert bubble into X/M
- busy  output  1  operation in flight
- md_done  output  1  one cycle; wb_* valid, X/M latches wb_* instead of ALU output
- wb_en  output  1  register write enable for the multdiv result
- wb_reg  output  5  destination register
- wb_data  output  32  writeback value

Behaviour:
- Decode: opcode = x_instr[31:27], aluop = x_instr[6:2], rd = x_instr[26:22].
  - mul: opcode 00000, aluop 00110.
  - div: opcode 00000, aluop 00111.
  - trigger = x_valid & ~flush & (mul | div).
- States: IDLE, BUSY, DONE. Two-bit state register, asynchronous clear to IDLE.
- IDLE:
  - stall = trigger (combinational, same cycle).
  - On trigger: latch op (mul/div) and rd, clear counter, go to BUSY.
- BUSY:
  - stall = 1, busy = 1.
  - First BUSY cycle: exactly one of ctrl_mult/ctrl_div = 1 (registered). Both are 0 otherwise.
  - Counter increments each BUSY cycle and saturates at MAX_WAIT.
  - md_ready is ignored in the first BUSY cycle.
  - On md_ready (counter >= 1): capture md_result and md_exception, go to DONE.
  - On counter == MAX_WAIT with no md_ready: capture exception = 1, go to DONE.
  - If md_ready and timeout occur in the same cycle, md_ready wins.
- DONE (exactly one cycle):
  - stall = 0, md_done = 1, busy = 0; the instruction advances X->M at the end of this cycle.
  - The trigger decode is ignored in DONE; the same instruction never restarts.
  - Next state is IDLE.
- Writeback values, driven only while md_done = 1:
  - No exception: wb_reg = latched rd, wb_data = captured result, wb_en = (rd != 0).
  - Exception: wb_reg = 30, wb_data = 4 (mul) or 5 (div), wb_en = 1.
- Outside DONE: wb_en = 0, md_done = 0, wb_reg = 0, wb_data = 0.
- flush:
  - In IDLE: suppresses trigger.
  - In BUSY: abort to IDLE next cycle; no md_done, no writeback; stall drops the cycle after flush. A later md_ready is ignored.
- Reset (any time, including mid-operation): state IDLE, counter 0, latched op/rd/result 0, all outputs 0.
- A mul/div immediately behind another is accepted in the IDLE cycle following DONE (no gap beyond that).

Test Plan:
- mul $5,$2,$3 in X with x_valid=1 -> stall=1 same cycle; ctrl_mult=1 for exactly one cycle; md_ready=1 with md_result=0x0000002A after 17 cycles -> next cycle md_done=1, wb_en=1, wb_reg=5, wb_data=0x2A, stall=0.
- div $7,$1,$0 with md_ready=1 and md_exception=1 -> md_done with wb_reg=30, wb_data=5, wb_en=1; ctrl_div pulsed once, ctrl_mult never.
- mul with rd=0 and result 0x1234 -> md_done=1, wb_en=0.
- md_ready never asserted -> after MAX_WAIT=40 BUSY cycles, DONE with wb_reg=30, wb_data=4.
- Back-to-back mul, div -> two separate start pulses; second stall begins in the IDLE cycle right after the first DONE; two md_done pulses.
- flush asserted on BUSY cycle 3 -> IDLE next cycle, stall=0, no md_done even when md_ready arrives later.
- reset pulled low mid-BUSY -> all outputs 0 immediately (asynchronous); after release, state is IDLE.
